// File: rtl/move_select_if.sv
// Board-pin / game-controller bundle for move_select.
// The DUT side uses the slave modport; the driving side uses master.
interface move_select_if #(
  parameter int N  = 3,
  parameter int IW = $clog2(N*N+1)
);
  logic [2*N-1:0] switch;
  logic           button;
  logic [N*N-1:0] occupied;
  logic           move_ready;
  logic [IW-1:0]  place;
  logic [IW-1:0]  move;
  logic           move_valid;
  logic           reject;
  logic           busy;
  logic           state_dbg;

  modport master (
    output switch, button, occupied, move_ready,
    input  place, move, move_valid, reject, busy, state_dbg
  );

  modport slave (
    input  switch, button, occupied, move_ready,
    output place, move, move_valid, reject, busy, state_dbg
  );
endinterface

// File: rtl/move_select.sv
// Move-entry front end: one-hot switch decode, button debounce, legality check and
// move handoff. Define MOVE_SELECT_OCC_CHECK_EN to also reject already-occupied cells.
module move_select #(
  parameter int N         = 3,
  parameter int DB_CYCLES = 4,
  parameter int IW        = $clog2(N*N+1)
) (
  input  logic         clk,
  input  logic         reset,
  move_select_if.slave bus
);

  // Handshake: move_valid stays high with move stable until the edge where
  // move_valid && move_ready; that edge completes the transfer.
  typedef enum logic {IDLE = 1'b0, PENDING = 1'b1} state_t;

  localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

  state_t        state_q, state_d;
  logic [IW-1:0] move_q, move_d;
  logic          reject_q, reject_d;
  logic          sync1_q, sync2_q, db_q, db_prev_q;
  logic [CW-1:0] cnt_q;
  logic          press;
  logic [N-1:0]  rows, cols;
  logic [IW-1:0] place_c;
  logic          occ_hit;
  logic          legal;
  int            row_i, col_i;

  function automatic logic is_onehot(input logic [N-1:0] v);
    return (v != '0) && ((v & (v - N'(1))) == '0);
  endfunction

  assign rows = bus.switch[2*N-1:N];
  assign cols = bus.switch[N-1:0];

  // Row 1 / column 1 sit at the MSB of their field.
  always_comb begin
    row_i   = 0;
    col_i   = 0;
    place_c = '0;
    occ_hit = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (rows[N-1-i]) row_i = i;
      if (cols[N-1-i]) col_i = i;
    end
    if (is_onehot(rows) && is_onehot(cols)) begin
      place_c = IW'(row_i * N + col_i + 1);
`ifdef MOVE_SELECT_OCC_CHECK_EN
      for (int k = 0; k < N*N; k++) begin
        if (k == row_i * N + col_i) occ_hit = bus.occupied[k];
      end
`endif
    end
  end

`ifdef MOVE_SELECT_OCC_CHECK_EN
  assign legal = (place_c != '0) && !occ_hit;
`else
  logic unused_occ;
  assign unused_occ = ^{bus.occupied, occ_hit};
  assign legal      = (place_c != '0);
`endif

  assign bus.place = place_c;

  // Debounced level flips only after DB_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      db_q      <= 1'b0;
      db_prev_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      sync1_q   <= bus.button;
      sync2_q   <= sync1_q;
      db_prev_q <= db_q;
      if (sync2_q != db_q) begin
        if (cnt_q == CW'(DB_CYCLES - 1)) begin
          db_q  <= sync2_q;
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_q + CW'(1);
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end

  assign press = db_q & ~db_prev_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      move_q   <= '0;
      reject_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      move_q   <= move_d;
      reject_q <= reject_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    move_d   = move_q;
    reject_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (press) begin
          if (legal) begin
            move_d  = place_c;
            state_d = PENDING;
          end else begin
            reject_d = 1'b1;
          end
        end else if (place_c == '0) begin
          move_d = '0;
        end
      end
      PENDING: begin
        // Presses here are dropped; only the controller can release the move.
        if (bus.move_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.move       = move_q;
  assign bus.move_valid = (state_q == PENDING);
  assign bus.busy       = (state_q == PENDING);
  assign bus.reject     = reject_q;
  assign bus.state_dbg  = state_q;

endmodule

// File: tb/tb_move_select.sv
// Bench for move_select: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a behavioural model.
module tb_move_select;
  localparam int N  = 3;
  localparam int DB = 4;
  localparam int IW = $clog2(N*N+1);

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_bad;

  move_select_if #(.N(N), .IW(IW)) bus ();

  move_select #(.N(N), .DB_CYCLES(DB), .IW(IW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic int model_place(input logic [2*N-1:0] sw);
    int r, c;
    r = 0;
    c = 0;
    if ($countones(sw[2*N-1:N]) != 1 || $countones(sw[N-1:0]) != 1) return 0;
    for (int i = 0; i < N; i++) begin
      if (sw[N+i]) r = N - i;
      if (sw[i])   c = N - i;
    end
    return (r - 1) * N + c;
  endfunction

  logic [31:0] m_hist;   // bit0 = newest raw button sample
  logic        m_db, m_db_prev, m_pend, m_rej;
  int          m_move;

  always @(posedge clk) begin : model
    logic press, legal, flip, pend_n, rej_n;
    int   pl, mv_n;
    if (reset) begin
      m_hist    <= '0;
      m_db      <= 1'b0;
      m_db_prev <= 1'b0;
      m_pend    <= 1'b0;
      m_rej     <= 1'b0;
      m_move    <= 0;
    end else begin
      press = m_db && !m_db_prev;
      pl    = model_place(bus.switch);
`ifdef MOVE_SELECT_OCC_CHECK_EN
      legal = (pl != 0) && !bus.occupied[pl-1];
`else
      legal = (pl != 0);
`endif
      pend_n = m_pend;
      mv_n   = m_move;
      rej_n  = 1'b0;
      if (!m_pend) begin
        if (press) begin
          if (legal) begin
            mv_n   = pl;
            pend_n = 1'b1;
          end else begin
            rej_n = 1'b1;
          end
        end else if (pl == 0) begin
          mv_n = 0;
        end
      end else if (bus.move_ready) begin
        pend_n = 1'b0;
      end
      // Synchronised sample seen at this edge is the raw sample from two edges back;
      // the level flips once the last DB such samples all disagree with it.
      flip = 1'b1;
      for (int k = 1; k <= DB; k++) if (m_hist[k] == m_db) flip = 1'b0;
      m_db      <= flip ? ~m_db : m_db;
      m_db_prev <= m_db;
      m_hist    <= {m_hist[30:0], bus.button};
      m_pend    <= pend_n;
      m_move    <= mv_n;
      m_rej     <= rej_n;
    end
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    check("place",      int'(bus.place),      model_place(bus.switch));
    check("move",       int'(bus.move),       m_move);
    check("move_valid", int'(bus.move_valid), int'(m_pend));
    check("busy",       int'(bus.busy),       int'(m_pend));
    check("reject",     int'(bus.reject),     int'(m_rej));
    check("state_dbg",  int'(bus.state_dbg),  int'(m_pend));
  end

  // ---------------- driver tasks ----------------
  task automatic start_press(input logic [2*N-1:0] sw);
    bus.switch  = sw;
    bus.button  = 1'b1;
    repeat (7) tick();
  endtask

  task automatic finish_press();
    repeat (3) tick();
    bus.button = 1'b0;
    repeat (10) tick();
  endtask

  task automatic accept();
    bus.move_ready = 1'b1;
    tick();
    bus.move_ready = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [N-1:0]   oh_r, oh_c;
    logic [2*N-1:0] sw;
    n_cmp          = 0;
    n_bad          = 0;
    reset          = 1'b1;
    bus.switch     = '0;
    bus.button     = 1'b0;
    bus.occupied   = '0;
    bus.move_ready = 1'b0;
    repeat (3) tick();
    check("reset_move_valid", int'(bus.move_valid), 0);
    check("reset_move",       int'(bus.move),       0);
    check("reset_busy",       int'(bus.busy),       0);
    reset = 1'b0;
    repeat (2) tick();

    bus.switch = 6'b100100;
    #1 check("decode_cell1", int'(bus.place), 1);
    bus.switch = 6'b001001;
    #1 check("decode_cell9", int'(bus.place), 9);

    // clean press, latency, hold, accept
    bus.switch = 6'b010010;
    bus.button = 1'b1;
    repeat (6) tick();
    check("lat_before", int'(bus.move_valid), 0);
    tick();
    check("lat_valid", int'(bus.move_valid), 1);
    check("lat_move",  int'(bus.move),       5);
    finish_press();
    check("hold_valid", int'(bus.move_valid), 1);
    check("hold_move",  int'(bus.move),       5);
    accept();
    check("acc_valid", int'(bus.move_valid), 0);
    check("acc_move",  int'(bus.move),       5);
    repeat (3) tick();

    // malformed selection
    start_press(6'b110010);
    check("bad_place",  int'(bus.place),      0);
    check("bad_reject", int'(bus.reject),     1);
    check("bad_valid",  int'(bus.move_valid), 0);
    check("bad_move",   int'(bus.move),       0);
    tick();
    check("bad_pulse", int'(bus.reject), 0);
    finish_press();

    // occupied cell
    bus.occupied = 9'b000000100;
    start_press(6'b100001);
`ifdef MOVE_SELECT_OCC_CHECK_EN
    check("occ_reject", int'(bus.reject),     1);
    check("occ_valid",  int'(bus.move_valid), 0);
`else
    check("occ_valid", int'(bus.move_valid), 1);
    check("occ_move",  int'(bus.move),       3);
`endif
    finish_press();
    accept();
    bus.occupied = '0;
    repeat (3) tick();

    // bounce shorter than the debounce window
    for (int i = 0; i < 10; i++) begin
      bus.button = ~bus.button;
      repeat (2) tick();
    end
    bus.button = 1'b0;
    repeat (10) tick();
    check("bounce_valid", int'(bus.move_valid), 0);

    // press during PENDING is dropped
    start_press(6'b100100);
    check("pend_move", int'(bus.move), 1);
    finish_press();
    start_press(6'b001100);
    check("drop_reject", int'(bus.reject), 0);
    finish_press();
    check("drop_move",  int'(bus.move),       1);
    check("drop_valid", int'(bus.move_valid), 1);
    accept();
    repeat (3) tick();
    start_press(6'b001100);
    check("next_move", int'(bus.move), 7);
    finish_press();
    accept();

    // reset while PENDING
    start_press(6'b010010);
    repeat (2) tick();
    bus.button = 1'b0;
    reset      = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_valid", int'(bus.move_valid), 0);
    check("rst_move",  int'(bus.move),       0);
    check("rst_busy",  int'(bus.busy),       0);
    repeat (10) tick();
    start_press(6'b010010);
    check("post_rst_move", int'(bus.move), 5);
    finish_press();
    accept();

    // randomized traffic
    for (int it = 0; it < 300; it++) begin
      case ($urandom_range(0, 3))
        0, 1: begin
          oh_r = '0;
          oh_c = '0;
          oh_r[$urandom_range(0, N-1)] = 1'b1;
          oh_c[$urandom_range(0, N-1)] = 1'b1;
          sw = {oh_r, oh_c};
        end
        2:       sw = 2*N'($urandom);
        default: sw = '0;
      endcase
      bus.switch     = sw;
      bus.occupied   = N*N'($urandom);
      bus.move_ready = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 39) == 0) begin
        reset = 1'b1;
        tick();
        reset = 1'b0;
      end
      bus.button = 1'b1;
      repeat ($urandom_range(1, 8)) tick();
      bus.button = 1'b0;
      repeat ($urandom_range(1, 8)) tick();
    end
    bus.move_ready = 1'b0;
    repeat (4) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/move_select.md
# move_select

Parametrised move-entry front end for the tic-tac-toe datapath: decodes an N×N board position from row/column one-hot switches, debounces the raw commit button, checks the cell against the board occupancy map, and delivers the move to the game controller over a valid/ready handshake. It sits between the board I/O pins and the game FSM. Unlike the earlier single-board input stage, it supports arbitrary board size, filters button bounce, rejects occupied or malformed selections, and holds a move until the controller accepts it.

## Interface
- `N`, default 3: board dimension, ≥2; board has N*N cells, numbered 1..N*N row-major.
- `DB_CYCLES`, default 4: consecutive stable samples required to change the debounced button level, ≥1.
- `IW`, default $clog2(N*N+1): derived cell-index width (4 for N=3); not overridden.
- `clk`  in  1  system clock, all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `switch`  in  2N  `[2N-1:N]` row one-hot (MSB = row 1), `[N-1:0]` column one-hot (MSB = column 1).
- `button`  in  1  raw, asynchronous, bouncy commit button.
- `occupied`  in  N*N  bit k-1 set = cell k already taken.
- `move_ready`  in  1  controller accepts `move`.
- `place`  out  IW  combinational decode of `switch`; 0 = illegal/none.
- `move`  out  IW  registered committed cell index.
- `move_valid`  out  1  `move` holds an unaccepted move.
- `reject`  out  1  one-cycle pulse: press on illegal or occupied selection.
- `busy`  out  1  high in PENDING.

## Operation
- Decode: `place` = (r-1)*N + c only when exactly one row bit (r) and exactly one column bit (c) are set; any other pattern → 0. For N=3, 6'b100100 → 1, 6'b001001 → 9.
- Button path: 2-flop synchroniser → debounce counter. Counter increments each edge the synchronised level differs from the debounced level and clears when equal; at DB_CYCLES consecutive differing samples the debounced level flips and counter clears. `press` = debounced rising edge (registered previous level), one cycle wide per physical press.
- FSM, two states:
  - IDLE: on `press`: if `place`≠0 and cell free → capture `place` into `move`, go PENDING. Otherwise pulse `reject`, stay IDLE. With no press and `place`==0, `move` clears to 0; otherwise `move` holds.
  - PENDING: `move_valid`=1, `busy`=1, `move` stable. On edge with `move_ready`=1 → IDLE, `move_valid` low next cycle, `move` holds accepted value.
- `switch` and `occupied` sampled only at the capture edge; later changes do not alter or retract a pending move.
- Press in PENDING: dropped, not queued, no `reject`.
- `move_ready` in IDLE: ignored.
- Reset values: `move`=0, `move_valid`=0, `reject`=0, `busy`=0, FSM=IDLE, synchroniser/debounced level/counter=0. Reset during PENDING discards the move.

## Timing
- Edge 1 = first edge sampling `button`=1, held stable: debounced level rises at edge 2+DB_CYCLES; `move_valid` (or `reject`) asserts after edge 3+DB_CYCLES (edge 7 for default).
- Release symmetric: debounced level falls at edge 2+DB_CYCLES after first low sample; no action on fall.
- Bounce shorter than DB_CYCLES samples produces no press.
- Handshake completes on the edge where `move_valid`&&`move_ready`; earliest next capture is the following cycle.
- `place` is purely combinational; no latency.

## Configuration
- `MOVE_SELECT_OCC_CHECK_EN` defined: capture additionally requires `occupied[place-1]`==0; occupied cell → `reject`.
- Undefined: `occupied` ignored; any `place`≠0 is captured; `reject` only for `place`==0.

## Test plan
- N=3, DB_CYCLES=4, switch=6'b010010, occupied=0, clean press held 10 cycles, move_ready=0 → `move_valid`=1 after edge 7, `move`=5, held until move_ready=1, then low one cycle later.
- Switch 6'b110010 (two rows) then press → `place`=0, one-cycle `reject`, `move_valid` stays 0, `move`=0.
- OCC_CHECK_EN defined, occupied=9'b000000100, switch=6'b100001, press → `reject` pulse, no move; same stimulus with macro undefined → `move`=3 captured.
- Button toggling every 2 cycles for 20 cycles then low → no press, no `reject`, `move_valid`=0.
- In PENDING with `move`=1, change switch to 6'b001100 and press again → `move` stays 1, no `reject`; after accept, new press captures 7.
- Assert reset two cycles into PENDING → next cycle `move_valid`=0, `move`=0, `busy`=0; subsequent press captures normally.
